// File: rtl/rx_frame_release_ctrl.sv
// Per-frame release scheduler: buffers one payload frame and forwards
// it to UART TX only after a passing CRC verdict, else drops it.
module rx_frame_release_ctrl #(
  parameter int PYLD_BYTES  = 16,
  parameter int CRC_TIMEOUT = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_pyld_data,
  input  logic        i_pyld_data_valid,
  output logic        o_pyld_ready,
  input  logic        i_crc_err,
  input  logic        i_crc_err_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_ack_req,
  output logic        o_nack_req,
  output logic [15:0] o_good_frames,
  output logic [15:0] o_bad_frames,
  output logic [7:0]  o_ovf_cnt,
  output logic        o_proto_err
);

  localparam int PW = $clog2(PYLD_BYTES + 1);
  localparam int AW = $clog2(PYLD_BYTES);
  localparam int TW = $clog2(CRC_TIMEOUT);
  localparam logic [PW-1:0] FULL  = PW'(PYLD_BYTES);
  localparam logic [PW-1:0] ONE   = PW'(1);
  localparam logic [TW-1:0] TLAST = TW'(CRC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_WAIT_CRC,
    S_RELEASE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    mem [PYLD_BYTES];
  logic [PW-1:0] wr_ptr, rd_ptr, len, wr_cnt;
  logic [TW-1:0] timer;
  logic          wr_en, rd_en, clr_ptrs, len_ld, tmr_clr;
  logic          ack_nxt, nack_nxt, proto_set, ovf_inc;
  logic          tx_valid;

  assign tx_valid     = (state == S_RELEASE) && (rd_ptr < len);
  assign o_tx_valid   = tx_valid;
  assign o_tx_data    = mem[rd_ptr[AW-1:0]];
  assign o_pyld_ready = (state == S_COLLECT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_COLLECT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    clr_ptrs  = 1'b0;
    len_ld    = 1'b0;
    tmr_clr   = 1'b0;
    ack_nxt   = 1'b0;
    nack_nxt  = 1'b0;
    proto_set = 1'b0;
    wr_cnt    = wr_ptr;
    ovf_inc   = i_pyld_data_valid && (state != S_COLLECT);
    unique case (state)
      S_COLLECT: begin
        wr_en  = i_pyld_data_valid;
        wr_cnt = wr_ptr + PW'(i_pyld_data_valid);
        // a verdict here closes a short frame, same-cycle byte included
        if (i_crc_err_valid) begin
          if (i_crc_err) begin
            nack_nxt = 1'b1;
            clr_ptrs = 1'b1;
          end else begin
            ack_nxt = 1'b1;
            if (wr_cnt == '0) begin
              clr_ptrs = 1'b1;
            end else begin
              len_ld    = 1'b1;
              state_nxt = S_RELEASE;
            end
          end
        end else if (wr_cnt == FULL) begin
          tmr_clr   = 1'b1;
          state_nxt = S_WAIT_CRC;
        end
      end
      S_WAIT_CRC: begin
        if (i_crc_err_valid && !i_crc_err) begin
          ack_nxt   = 1'b1;
          len_ld    = 1'b1;
          state_nxt = S_RELEASE;
        end else if (i_crc_err_valid || timer == TLAST) begin
          nack_nxt  = 1'b1;
          clr_ptrs  = 1'b1;
          state_nxt = S_COLLECT;
        end
      end
      S_RELEASE: begin
        proto_set = i_crc_err_valid;
        rd_en     = tx_valid && i_tx_ready;
        if (rd_en && (rd_ptr + ONE == len)) begin
          clr_ptrs  = 1'b1;
          state_nxt = S_COLLECT;
        end
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      len           <= '0;
      timer         <= '0;
      o_ack_req     <= 1'b0;
      o_nack_req    <= 1'b0;
      o_good_frames <= '0;
      o_bad_frames  <= '0;
      o_ovf_cnt     <= '0;
      o_proto_err   <= 1'b0;
    end else begin
      if (clr_ptrs) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_cnt;
        if (rd_en) rd_ptr <= rd_ptr + ONE;
      end
      if (len_ld) len <= wr_cnt;
      if (tmr_clr)                  timer <= '0;
      else if (state == S_WAIT_CRC) timer <= timer + TW'(1);
      o_ack_req     <= ack_nxt;
      o_nack_req    <= nack_nxt;
      o_good_frames <= o_good_frames + 16'(ack_nxt);
      o_bad_frames  <= o_bad_frames + 16'(nack_nxt);
      if (ovf_inc && o_ovf_cnt != 8'hFF)
        o_ovf_cnt <= o_ovf_cnt + 8'd1;
      if (proto_set) o_proto_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= i_pyld_data;
  end

endmodule

// File: tb/tb_rx_frame_release_ctrl.sv
// Randomized bench for rx_frame_release_ctrl against a frame-level
// model: expected release queue, verdict pulses and counters.
module tb_rx_frame_release_ctrl;

  localparam int NB = 16;
  localparam int T  = 32;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_pyld_data = '0;
  logic        i_pyld_data_valid = 1'b0;
  logic        o_pyld_ready;
  logic        i_crc_err = 1'b0;
  logic        i_crc_err_valid = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic        o_ack_req, o_nack_req;
  logic [15:0] o_good_frames, o_bad_frames;
  logic [7:0]  o_ovf_cnt;
  logic        o_proto_err;

  int n_chk = 0, n_pass = 0;
  int exp_good = 0, exp_bad = 0, exp_ovf = 0;
  int exp_acks = 0, exp_nacks = 0;
  int ack_seen = 0, nack_seen = 0;
  logic [7:0] got_q[$];
  bit         stall_q = 1'b0;
  logic [7:0] stall_d = '0;

  rx_frame_release_ctrl #(
    .PYLD_BYTES (NB),
    .CRC_TIMEOUT(T)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_pyld_data      (i_pyld_data),
    .i_pyld_data_valid(i_pyld_data_valid),
    .o_pyld_ready     (o_pyld_ready),
    .i_crc_err        (i_crc_err),
    .i_crc_err_valid  (i_crc_err_valid),
    .o_tx_data        (o_tx_data),
    .o_tx_valid       (o_tx_valid),
    .i_tx_ready       (i_tx_ready),
    .o_ack_req        (o_ack_req),
    .o_nack_req       (o_nack_req),
    .o_good_frames    (o_good_frames),
    .o_bad_frames     (o_bad_frames),
    .o_ovf_cnt        (o_ovf_cnt),
    .o_proto_err      (o_proto_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h t=%0t",
                  tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // byte offered while the block is not collecting: must be dropped
  task automatic drop_byte(input int pct);
    i_pyld_data       = 8'($urandom);
    i_pyld_data_valid = ($urandom_range(0, 99) < pct);
    if (i_pyld_data_valid && exp_ovf < 255) exp_ovf++;
  endtask

  task automatic chk_cnt();
    chk("good_frames", o_good_frames, exp_good);
    chk("bad_frames", o_bad_frames, exp_bad);
    chk("ovf_cnt", o_ovf_cnt, exp_ovf);
  endtask

  task automatic chk_bytes(input logic [7:0] fr[$], input int n);
    chk("rel_len", got_q.size(), n);
    for (int i = 0; i < got_q.size() && i < n; i++)
      chk("rel_byte", got_q[i], fr[i]);
    got_q.delete();
  endtask

  task automatic drain(input bit stall, output int cyc);
    cyc = 0;
    while (o_tx_valid && cyc < 4000) begin
      i_tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      drop_byte(stall ? 30 : 0);
      tick();
      cyc++;
    end
    i_pyld_data_valid = 1'b0;
    i_tx_ready = 1'b1;
    chk("release_done", o_tx_valid, 0);
  endtask

  // kind: 0 pass, 1 fail, 2 timeout (full frame only)
  task automatic run_frame(input int n, input int kind,
                           input bit coinc, input int gap,
                           input bit seqd, input bit stall);
    logic [7:0] fr[$];
    int cyc;
    bit pass;
    bit co;
    co = coinc && n > 0 && n < NB;
    pass = (kind == 0);
    chk("rdy_collect", o_pyld_ready, 1);
    for (int i = 0; i < n; i++) begin
      i_pyld_data = seqd ? 8'(i) : 8'($urandom);
      i_pyld_data_valid = 1'b1;
      fr.push_back(i_pyld_data);
      if (co && i == n - 1) begin
        i_crc_err_valid = 1'b1;
        i_crc_err = (kind == 1);
      end
      tick();
    end
    i_pyld_data_valid = 1'b0;
    if (!co) begin
      if (n == NB) chk("rdy_wait", o_pyld_ready, 0);
      if (kind == 2) begin
        for (int k = 1; k <= T; k++) begin
          drop_byte(25);
          tick();
          if (k == T - 1) chk("nack_early", o_nack_req, 0);
        end
      end else begin
        for (int k = 0; k < gap; k++) begin
          if (n == NB) drop_byte(25);
          tick();
        end
        i_pyld_data_valid = 1'b0;
        i_crc_err_valid = 1'b1;
        i_crc_err = (kind == 1);
        tick();
      end
    end
    i_pyld_data_valid = 1'b0;
    i_crc_err_valid = 1'b0;
    chk("ack_pulse", o_ack_req, pass);
    chk("nack_pulse", o_nack_req, !pass);
    if (pass) begin
      exp_good++;
      exp_acks++;
    end else begin
      exp_bad++;
      exp_nacks++;
    end
    if (pass && n > 0) begin
      chk("tx_valid_n1", o_tx_valid, 1);
      drain(stall, cyc);
      if (!stall) chk("release_cycles", cyc, n);
    end else begin
      chk("tx_valid_idle", o_tx_valid, 0);
    end
    chk("rdy_after", o_pyld_ready, 1);
    chk_bytes(fr, pass ? n : 0);
    chk_cnt();
  endtask

  always @(posedge i_clk) begin
    if (i_rst_n) begin
      if (stall_q) begin
        chk("stall_valid", o_tx_valid, 1);
        chk("stall_data", o_tx_data, stall_d);
      end
      if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
      if (o_ack_req) ack_seen++;
      if (o_nack_req) nack_seen++;
      if (o_ack_req || o_nack_req)
        chk("ack_nack_excl", o_ack_req & o_nack_req, 0);
    end
    stall_q = i_rst_n && o_tx_valid && !i_tx_ready;
    stall_d = o_tx_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    int cyc;
    int kr;
    tick();
    tick();
    i_rst_n = 1'b1;
    chk("rst_ready", o_pyld_ready, 1);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_ack", o_ack_req, 0);
    chk("rst_nack", o_nack_req, 0);
    chk("rst_proto", o_proto_err, 0);
    chk_cnt();

    run_frame(NB, 0, 0, 2, 1, 0);
    run_frame(NB, 1, 0, 3, 0, 0);
    run_frame(NB, 2, 0, 0, 0, 0);
    run_frame(NB, 0, 0, 1, 0, 1);
    run_frame(6, 0, 1, 0, 0, 0);
    run_frame(0, 0, 0, 1, 0, 0);
    run_frame(3, 1, 0, 2, 0, 0);

    // reset while releasing: bytes 0..3 out, then everything clears
    fr.delete();
    for (int i = 0; i < NB; i++) begin
      i_pyld_data = 8'($urandom);
      i_pyld_data_valid = 1'b1;
      fr.push_back(i_pyld_data);
      tick();
    end
    i_pyld_data_valid = 1'b0;
    i_crc_err_valid = 1'b1;
    i_crc_err = 1'b0;
    tick();
    i_crc_err_valid = 1'b0;
    exp_acks++;
    chk("rr_ack", o_ack_req, 1);
    for (int i = 0; i < 4; i++) tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    exp_good = 0;
    exp_bad = 0;
    exp_ovf = 0;
    chk("rr_tx_valid", o_tx_valid, 0);
    chk("rr_ready", o_pyld_ready, 1);
    chk("rr_ack_low", o_ack_req, 0);
    chk_cnt();
    chk_bytes(fr, 4);
    run_frame(NB, 0, 0, 1, 0, 0);

    for (int f = 0; f < 40; f++) begin
      kr = $urandom_range(0, 4);
      case (kr)
        0: run_frame(NB, 0, 0, $urandom_range(0, 5), 0, 1'($urandom));
        1: run_frame(NB, 1, 0, $urandom_range(0, 5), 0, 0);
        2: run_frame(NB, 2, 0, 0, 0, 0);
        3: run_frame($urandom_range(0, NB - 1), 0, 1'($urandom),
                     $urandom_range(0, 5), 0, 1'($urandom));
        default: run_frame($urandom_range(0, NB - 1), 1,
                           1'($urandom), $urandom_range(0, 5), 0, 0);
      endcase
    end

    // long stall: overflow saturates, verdict in RELEASE is a protocol error
    chk("proto_clear", o_proto_err, 0);
    fr.delete();
    for (int i = 0; i < NB; i++) begin
      i_pyld_data = 8'($urandom);
      i_pyld_data_valid = 1'b1;
      fr.push_back(i_pyld_data);
      tick();
    end
    i_pyld_data_valid = 1'b0;
    i_crc_err_valid = 1'b1;
    i_crc_err = 1'b0;
    tick();
    exp_good++;
    exp_acks++;
    chk("sat_ack", o_ack_req, 1);
    i_tx_ready = 1'b0;
    for (int k = 0; k < 300; k++) begin
      i_crc_err_valid = (k == 100);
      i_crc_err = 1'($urandom);
      i_pyld_data = 8'($urandom);
      i_pyld_data_valid = 1'b1;
      if (exp_ovf < 255) exp_ovf++;
      tick();
    end
    i_crc_err_valid = 1'b0;
    i_pyld_data_valid = 1'b0;
    chk("proto_set", o_proto_err, 1);
    chk("sat_tx_valid", o_tx_valid, 1);
    drain(1'b0, cyc);
    chk_bytes(fr, NB);
    chk_cnt();
    chk("proto_sticky", o_proto_err, 1);
    run_frame(5, 0, 0, 1, 0, 1);

    chk("ack_total", ack_seen, exp_acks);
    chk("nack_total", nack_seen, exp_nacks);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
